// File: rtl/subexpr_sched_ctrl.sv
// Area-reduced six-result arithmetic network: one shared add/sub and one shared
// multiplier stepped through a fixed 12-step schedule with shared subexpressions.
module subexpr_sched_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result1,
  output logic [WIDTH-1:0] result2,
  output logic [WIDTH-1:0] result3,
  output logic [WIDTH-1:0] result4,
  output logic [WIDTH-1:0] result5,
  output logic [WIDTH-1:0] result6,
  output logic             busy,
  output logic [3:0]       step,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
  logic [WIDTH-1:0] sab, mcd, sef, t0, t1;
  logic [WIDTH-1:0] add_x, add_y, add_res;
  logic [WIDTH-1:0] mul_x, mul_y, mul_res;
  logic             add_sub;
  logic             accept;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; out_valid stays high with results frozen until out_ready is seen.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    mul_x   = '0;
    mul_y   = '0;
    case (step)
      4'd0:  begin add_x = op_a; add_y = op_b; mul_x = op_c; mul_y = op_d; end
      4'd1:  begin add_x = op_e; add_y = op_f; add_sub = 1'b1; end
      4'd2:  begin add_x = sab;  add_y = mcd;  end
      4'd3:  begin add_x = mcd;  add_y = sef;  end
      4'd4:  begin add_x = sab;  add_y = op_g; end
      4'd5:  begin add_x = t0;   add_y = op_h; end
      4'd6:  begin add_x = mcd;  add_y = op_e; end
      4'd7:  begin add_x = mcd;  add_y = op_b; mul_x = t0; mul_y = sab; end
      4'd8:  begin add_x = op_f; add_y = sab;  end
      4'd9:  begin add_x = t1;   add_y = t0;   add_sub = 1'b1; end
      4'd10: begin add_x = sab;  add_y = op_c; end
      4'd11: begin mul_x = t0;   mul_y = sef;  end
      default: ;
    endcase
  end

  assign add_res = add_sub ? (add_x - add_y) : (add_x + add_y);
  // Only the low WIDTH bits of the product are kept.
  assign mul_res = mul_x * mul_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step <= '0; busy <= 1'b0; out_valid <= 1'b0;
      op_a <= '0; op_b <= '0; op_c <= '0; op_d <= '0;
      op_e <= '0; op_f <= '0; op_g <= '0; op_h <= '0;
      sab <= '0; mcd <= '0; sef <= '0; t0 <= '0; t1 <= '0;
      result1 <= '0; result2 <= '0; result3 <= '0;
      result4 <= '0; result5 <= '0; result6 <= '0;
    end else begin
      case (state)
        RUN: begin
          case (step)
            4'd0:  begin sab <= add_res; mcd <= mul_res; end
            4'd1:  sef <= add_res;
            4'd2:  result1 <= add_res;
            4'd3:  result2 <= add_res;
            4'd4:  t0 <= add_res;
            4'd5:  result3 <= add_res;
            4'd6:  t0 <= add_res;
            4'd7:  begin t1 <= add_res; result4 <= mul_res; end
            4'd8:  t0 <= add_res;
            4'd9:  result5 <= add_res;
            4'd10: t0 <= add_res;
            4'd11: result6 <= mul_res;
            default: ;
          endcase
          if (step == 4'd11) begin
            step <= '0; busy <= 1'b0; out_valid <= 1'b1; state <= DONE;
          end else begin
            step <= step + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
      // Accept from IDLE or straight out of DONE; overrides the DONE->IDLE move.
      if (accept) begin
        op_a <= a; op_b <= b; op_c <= c; op_d <= d;
        op_e <= e; op_f <= f; op_g <= g; op_h <= h;
        step <= '0; busy <= 1'b1; state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_subexpr_sched_ctrl.sv
// Randomized self-checking bench for subexpr_sched_ctrl with a closed-form
// model of the six results.
module tb_subexpr_sched_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0, e = '0, f = '0, g = '0, h = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result1, result2, result3, result4, result5, result6;
  logic         busy;
  logic [3:0]   step;
  logic [1:0]   dbg_state;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] op[8];
  logic [W-1:0] got[6];

  subexpr_sched_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .out_valid(out_valid), .out_ready(out_ready),
    .result1(result1), .result2(result2), .result3(result3),
    .result4(result4), .result5(result5), .result6(result6),
    .busy(busy), .step(step), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always_comb begin
    got[0] = result1; got[1] = result2; got[2] = result3;
    got[3] = result4; got[4] = result5; got[5] = result6;
  end

  // reference model: closed-form expressions of the six results
  task automatic push_model();
    logic [W-1:0] r[6];
    r[0] = op[0] + op[1] + op[2] * op[3];
    r[1] = op[2] * op[3] + op[4] - op[5];
    r[2] = op[0] + op[1] + op[6] + op[7];
    r[3] = (op[2] * op[3] + op[4]) * (op[0] + op[1]);
    r[4] = (op[2] * op[3] + op[1]) - (op[5] + op[0] + op[1]);
    r[5] = (op[0] + op[1] + op[2]) * (op[4] - op[5]);
    for (int i = 0; i < 6; i++) exp_q.push_back(r[i]);
  endtask

  // driver tasks
  task automatic drive_ops();
    a = op[0]; b = op[1]; c = op[2]; d = op[3];
    e = op[4]; f = op[5]; g = op[6]; h = op[7];
  endtask

  task automatic random_ops();
    for (int i = 0; i < 8; i++) op[i] = $urandom;
  endtask

  task automatic accept_set();
    drive_ops();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Waits for out_valid; counts samples where busy/step differ from the RUN sequence.
  task automatic wait_done(input bit scramble, output int lat, output int bad_seq);
    lat = 0;
    bad_seq = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1 || step !== 4'(lat)) bad_seq++;
      if (scramble) begin
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        e = $urandom; f = $urandom; g = $urandom; h = $urandom;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || step !== 4'd0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b step=%0d want 1 0 0 0",
               in_ready, out_valid, busy, step);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== '0) begin
        errors++;
        $display("FAIL reset_result%0d: got %h want 0", i + 1, got[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] ops_in[8],
                               input logic [W-1:0] want[6]);
    int lat, bad;
    op = ops_in;
    for (int i = 0; i < 6; i++) exp_q.push_back(want[i]);
    accept_set();
    wait_done(1'b0, lat, bad);
    checks++;
    if (lat !== 12 || bad !== 0) begin
      errors++;
      $display("FAIL %s_latency: latency=%0d bad_seq=%0d want 12 0", name, lat, bad);
    end
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] x;
      x = exp_q.pop_front();
      checks++;
      if (got[i] !== x) begin
        errors++;
        $display("FAIL %s_result%0d: got %h want %h", name, i + 1, got[i], x);
      end
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || step !== 4'd0) begin
      errors++;
      $display("FAIL %s_done_ctrl: in_ready=%b busy=%b step=%0d want 0 0 0",
               name, in_ready, busy, step);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b busy=%b want 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    int lat, bad;
    logic [W-1:0] want[6];
    random_ops();
    push_model();
    accept_set();
    wait_done(1'b0, lat, bad);
    for (int i = 0; i < 6; i++) want[i] = exp_q.pop_front();
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      e = $urandom; f = $urandom; g = $urandom; h = $urandom;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b busy=%b want 1 0 0",
                 k, out_valid, in_ready, busy);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++;
          $display("FAIL bp_result%0d: cycle %0d got %h want %h", i + 1, k, got[i], want[i]);
        end
      end
    end
    in_valid = 1'b0;
    release_out();
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b busy=%b in_ready=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bad1, bad2;
    random_ops();
    push_model();
    out_ready = 1'b1;
    drive_ops();
    in_valid = 1'b1;
    @(posedge clk); #1;
    random_ops();
    push_model();
    drive_ops();
    wait_done(1'b0, lat1, bad1);
    checks++;
    if (lat1 !== 12 || bad1 !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: latency=%0d bad_seq=%0d in_ready=%b want 12 0 1",
               lat1, bad1, in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] x;
      x = exp_q.pop_front();
      checks++;
      if (got[i] !== x) begin
        errors++;
        $display("FAIL b2b_first_result%0d: got %h want %h", i + 1, got[i], x);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || step !== 4'd0) begin
      errors++;
      $display("FAIL b2b_reaccept: out_valid=%b busy=%b step=%0d want 0 1 0",
               out_valid, busy, step);
    end
    wait_done(1'b0, lat2, bad2);
    checks++;
    if (lat2 + 1 !== 13 || bad2 !== 0) begin
      errors++;
      $display("FAIL b2b_spacing: spacing=%0d bad_seq=%0d want 13 0", lat2 + 1, bad2);
    end
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] x;
      x = exp_q.pop_front();
      checks++;
      if (got[i] !== x) begin
        errors++;
        $display("FAIL b2b_second_result%0d: got %h want %h", i + 1, got[i], x);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_random(input int n, input bit scramble);
    int lat, bad;
    for (int t = 0; t < n; t++) begin
      random_ops();
      push_model();
      accept_set();
      wait_done(scramble, lat, bad);
      checks++;
      if (lat !== 12 || bad !== 0) begin
        errors++;
        $display("FAIL rand_latency: txn %0d latency=%0d bad_seq=%0d want 12 0", t, lat, bad);
      end
      for (int i = 0; i < 6; i++) begin
        logic [W-1:0] x;
        x = exp_q.pop_front();
        checks++;
        if (got[i] !== x) begin
          errors++;
          $display("FAIL rand_result%0d: txn %0d got %h want %h", i + 1, t, got[i], x);
        end
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      release_out();
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    random_ops();
    push_model();
    accept_set();
    n = 0;
    while (step !== 4'd6 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (step !== 4'd6) begin
      errors++;
      $display("FAIL midrst_reach: step=%0d want 6", step);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || step !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ctrl: out_valid=%b busy=%b step=%0d in_ready=%b want 0 0 0 1",
               out_valid, busy, step, in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      void'(exp_q.pop_front());
      checks++;
      if (got[i] !== '0) begin
        errors++;
        $display("FAIL midrst_result%0d: got %h want 0", i + 1, got[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_random(1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] basic_ops[8];
    logic [W-1:0] basic_res[6];
    logic [W-1:0] wrap_ops[8];
    logic [W-1:0] wrap_res[6];
    basic_ops = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd5, 32'd7, 32'd8};
    basic_res = '{32'd15, 32'd17, 32'd18, 32'd66, 32'd6, 32'd30};
    wrap_ops  = '{32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 32'h0001_0000,
                  32'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    wrap_res  = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_0000};

    test_reset();
    test_directed("basic", basic_ops, basic_res);
    test_directed("wrap", wrap_ops, wrap_res);
    test_backpressure();
    test_back_to_back();
    test_random(4, 1'b1);
    test_reset_mid_run();
    test_random(6, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
